keypad_arm_ctrl: RTL and testbench
==================================

// Module: keypad_arm_ctrl
// PURPOSE
//   Passcode entry front-end that produces the 2-bit KEY command consumed by the security FSM.
//   - A keypad scanner delivers one strobe per digit; ENTER commits the entry.
//   - A correct 4-digit code drives KEY=2'b11 (arm) or KEY=2'b00 (disarm) for a short burst.
//   - Repeated wrong codes trigger a timed lockout.
//   - Sits between the keypad scanner and the alarm FSM; KEY rests at neutral 2'b01.
// PARAMETERS
//   CLK_FREQ      1_250_000  CLK cycles per tick (10 ms at 125 MHz)
//   CODE          16'h1234   passcode, 4 nibbles, first-entered digit in [15:12]
//   MAX_FAIL      3          consecutive failed entries that trigger lockout (>=1)
//   LOCK_TICKS    3000       lockout duration in ticks (30 s)
//   TIMEOUT_TICKS 500        idle ticks inside an entry before it is abandoned (5 s)
//   CMD_CYCLES    4          CLK cycles KEY holds an arm/disarm command (>=1)
// PORTS
//   CLK        in   1   clock
//   RST        in   1   synchronous reset, active-high
//   DIGIT      in   4   digit value, sampled only when DIGIT_STB=1
//   DIGIT_STB  in   1   one-cycle digit strobe
//   ENTER_STB  in   1   one-cycle commit strobe
//   CMD_SEL    in   1   sampled with ENTER_STB: 1=arm, 0=disarm
//   KEY        out  2   command to alarm FSM: 11 arm, 00 disarm, 01 neutral
//   LOCKED     out  1   high throughout lockout
//   ERR        out  1   one-cycle pulse on each rejected entry
//   NDIG       out  3   digits held in current entry, 0..4
// BEHAVIOUR
//   Reset values:
//     - KEY=2'b01; LOCKED=0; ERR=0; NDIG=0.
//     - State IDLE; fail count, tick prescaler, timers and digit register all cleared.
//   Tick prescaler:
//     - Free-running 0..CLK_FREQ-1.
//     - Emits a one-cycle tick on wrap.
//     - Timer accuracy is -1/+0 tick.
//   States:
//     IDLE
//       - DIGIT_STB: shift DIGIT in, NDIG=1, clear timeout, go to COLLECT.
//       - ENTER_STB alone is ignored.
//     COLLECT
//       - DIGIT_STB with NDIG<4: shift in, NDIG++, clear timeout.
//       - DIGIT_STB with NDIG=4: ignored, but still clears the timeout.
//       - ENTER_STB: latch CMD_SEL, go to CHECK.
//       - Timeout reaches TIMEOUT_TICKS: clear entry, go to IDLE, fail count unchanged, no ERR.
//     CHECK (exactly 1 cycle)
//       - Pass: NDIG==4 and digits==CODE. Clear fail count, go to ISSUE.
//       - Fail: ERR=1 this cycle, fail count++.
//         - If the new count reaches MAX_FAIL, go to LOCKOUT.
//         - Otherwise go to IDLE.
//       - Entry cleared (NDIG=0) on exit either way.
//     ISSUE
//       - KEY = CMD_SEL ? 11 : 00 for exactly CMD_CYCLES cycles, starting the cycle after CHECK.
//       - Then KEY=01 and go to IDLE.
//       - Strobes during ISSUE are ignored.
//     LOCKOUT
//       - LOCKED=1; all strobes ignored.
//       - After LOCK_TICKS ticks: LOCKED=0, fail count=0, go to IDLE.
//   Other rules:
//     - KEY is registered and is 01 in every state except ISSUE. It never glitches through 00 or 11.
//     - DIGIT_STB and ENTER_STB in the same cycle: ENTER wins, the digit is discarded.
//     - DIGIT values 10..15 are accepted verbatim; they only fail against CODE.
//     - RST in any state, including mid-ISSUE or mid-LOCKOUT, takes effect next cycle.
//       KEY returns to 01 immediately.
// TESTING  (CLK_FREQ=4, LOCK_TICKS=5, TIMEOUT_TICKS=3, CMD_CYCLES=4, MAX_FAIL=3)
//   1. Digits 1,2,3,4 then ENTER with CMD_SEL=1 -> ERR=0. KEY=11 for exactly 4 cycles starting 2 cycles after ENTER, then 01.
//   2. Digits 1,2,3,5 then ENTER -> one-cycle ERR. KEY stays 01. NDIG returns to 0.
//   3. Three wrong entries -> LOCKED=1 after the third. Correct code during lockout gives no KEY change. LOCKED falls after 5 ticks (~20 cycles). Correct code then works.
//   4. Digits 1,2 then silence for 3+ ticks -> NDIG=0. No ERR. Later correct code + ENTER CMD_SEL=0 -> KEY=00 for 4 cycles.
//   5. Digits 1,2,3,4,9 then ENTER -> fifth digit ignored; pass. DIGIT_STB+ENTER_STB in the same cycle after 1,2,3,4 -> pass.
//   6. RST asserted in the 2nd ISSUE cycle -> KEY=01 next cycle. NDIG=0, LOCKED=0, fail count 0 (verify with 2 fails + 1 fail, no lockout).

Source files
------------

// File: rtl/keypad_arm_ctrl.sv
// Passcode entry front-end: collects keypad digits, checks them against CODE on ENTER and
// issues a short arm/disarm command on KEY, with a timed lockout after repeated failures.
//
// state     | meaning
// S_IDLE    | no entry in progress, waiting for the first digit
// S_COLLECT | digits being entered, idle timeout running
// S_CHECK   | one cycle: compare entry against CODE, ERR pulses on failure
// S_ISSUE   | KEY drives arm/disarm for CMD_CYCLES cycles
// S_LOCKOUT | too many failures, all strobes ignored until the lock timer expires
module keypad_arm_ctrl #(
   parameter int          CLK_FREQ      = 1_250_000,
   parameter logic [15:0] CODE          = 16'h1234,
   parameter int          MAX_FAIL      = 3,
   parameter int          LOCK_TICKS    = 3000,
   parameter int          TIMEOUT_TICKS = 500,
   parameter int          CMD_CYCLES    = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] DIGIT,
   input  logic       DIGIT_STB,
   input  logic       ENTER_STB,
   input  logic       CMD_SEL,
   output logic [1:0] KEY,
   output logic       LOCKED,
   output logic       ERR,
   output logic [2:0] NDIG
);

   localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam int FW = $clog2(MAX_FAIL + 1);
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   localparam int LW = $clog2(LOCK_TICKS + 1);
   localparam int CW = (CMD_CYCLES > 1) ? $clog2(CMD_CYCLES) : 1;

   localparam logic [1:0] KEY_ARM     = 2'b11;
   localparam logic [1:0] KEY_DISARM  = 2'b00;
   localparam logic [1:0] KEY_NEUTRAL = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_CHECK,
      S_ISSUE,
      S_LOCKOUT
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   digits_q, digits_d;
   logic [2:0]    ndig_q, ndig_d;
   logic [FW-1:0] fail_q, fail_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic [CW-1:0] cmd_cnt_q, cmd_cnt_d;
   logic          cmd_sel_q, cmd_sel_d;
   logic [1:0]    key_q, key_d;
   logic          locked_q, locked_d;
   logic          err_q, err_d;
   logic          tick;
   logic          entry_ok;

   assign tick     = (presc_q == PW'(CLK_FREQ - 1));
   assign entry_ok = (ndig_q == 3'd4) && (digits_q == CODE);

   always_comb begin
      presc_d    = tick ? '0 : presc_q + PW'(1);
      state_d    = state_q;
      digits_d   = digits_q;
      ndig_d     = ndig_q;
      fail_d     = fail_q;
      tmo_d      = tmo_q;
      lock_cnt_d = lock_cnt_q;
      cmd_cnt_d  = cmd_cnt_q;
      cmd_sel_d  = cmd_sel_q;
      key_d      = key_q;
      locked_d   = locked_q;
      err_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // ENTER wins over a simultaneous digit, and ENTER alone does nothing here
            if (!ENTER_STB && DIGIT_STB) begin
               digits_d = {digits_q[11:0], DIGIT};
               ndig_d   = 3'd1;
               tmo_d    = TW'(TIMEOUT_TICKS);
               state_d  = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (ENTER_STB) begin
               cmd_sel_d = CMD_SEL;
               err_d     = !entry_ok;
               state_d   = S_CHECK;
            end else if (DIGIT_STB) begin
               tmo_d = TW'(TIMEOUT_TICKS);
               if (ndig_q < 3'd4) begin
                  digits_d = {digits_q[11:0], DIGIT};
                  ndig_d   = ndig_q + 3'd1;
               end
            end else if (tick) begin
               if (tmo_q <= TW'(1)) begin
                  digits_d = '0;
                  ndig_d   = '0;
                  state_d  = S_IDLE;
               end else begin
                  tmo_d = tmo_q - TW'(1);
               end
            end
         end
         S_CHECK: begin
            digits_d = '0;
            ndig_d   = '0;
            if (entry_ok) begin
               fail_d    = '0;
               key_d     = cmd_sel_q ? KEY_ARM : KEY_DISARM;
               cmd_cnt_d = CW'(CMD_CYCLES - 1);
               state_d   = S_ISSUE;
            end else if (fail_q == FW'(MAX_FAIL - 1)) begin
               fail_d     = fail_q + FW'(1);
               locked_d   = 1'b1;
               lock_cnt_d = LW'(LOCK_TICKS);
               state_d    = S_LOCKOUT;
            end else begin
               fail_d  = fail_q + FW'(1);
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (cmd_cnt_q == '0) begin
               key_d   = KEY_NEUTRAL;
               state_d = S_IDLE;
            end else begin
               cmd_cnt_d = cmd_cnt_q - CW'(1);
            end
         end
         S_LOCKOUT: begin
            if (tick) begin
               if (lock_cnt_q <= LW'(1)) begin
                  locked_d = 1'b0;
                  fail_d   = '0;
                  state_d  = S_IDLE;
               end else begin
                  lock_cnt_d = lock_cnt_q - LW'(1);
               end
            end
         end
         default: begin
            key_d    = KEY_NEUTRAL;
            locked_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         presc_q    <= '0;
         digits_q   <= '0;
         ndig_q     <= '0;
         fail_q     <= '0;
         tmo_q      <= '0;
         lock_cnt_q <= '0;
         cmd_cnt_q  <= '0;
         cmd_sel_q  <= 1'b0;
         key_q      <= KEY_NEUTRAL;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         digits_q   <= digits_d;
         ndig_q     <= ndig_d;
         fail_q     <= fail_d;
         tmo_q      <= tmo_d;
         lock_cnt_q <= lock_cnt_d;
         cmd_cnt_q  <= cmd_cnt_d;
         cmd_sel_q  <= cmd_sel_d;
         key_q      <= key_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
      end
   end

   assign KEY    = key_q;
   assign LOCKED = locked_q;
   assign ERR    = err_q;
   assign NDIG   = ndig_q;

endmodule

// File: tb/tb_keypad_arm_ctrl.sv
// Directed bench for keypad_arm_ctrl with a short tick (4 cycles) so timeouts and lockout are quick.
// Inputs change and outputs are sampled on the falling edge.
module tb_keypad_arm_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] DIGIT = 4'h0;
   logic       DIGIT_STB = 1'b0;
   logic       ENTER_STB = 1'b0;
   logic       CMD_SEL = 1'b0;
   logic [1:0] KEY;
   logic       LOCKED;
   logic       ERR;
   logic [2:0] NDIG;

   int checks = 0;
   int errors = 0;

   keypad_arm_ctrl #(
      .CLK_FREQ(4), .CODE(16'h1234), .MAX_FAIL(3),
      .LOCK_TICKS(5), .TIMEOUT_TICKS(3), .CMD_CYCLES(4)
   ) dut (
      .CLK(CLK), .RST(RST), .DIGIT(DIGIT), .DIGIT_STB(DIGIT_STB),
      .ENTER_STB(ENTER_STB), .CMD_SEL(CMD_SEL), .KEY(KEY),
      .LOCKED(LOCKED), .ERR(ERR), .NDIG(NDIG)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic press_digit(input logic [3:0] d);
      DIGIT = d; DIGIT_STB = 1'b1;
      @(negedge CLK);
      DIGIT_STB = 1'b0;
   endtask

   task automatic press_enter(input logic sel);
      ENTER_STB = 1'b1; CMD_SEL = sel;
      @(negedge CLK);
      ENTER_STB = 1'b0; CMD_SEL = 1'b0;
   endtask

   // Returns in the CHECK cycle (ERR visible, KEY not yet changed).
   task automatic enter_code(input logic [15:0] c, input logic sel);
      for (int i = 0; i < 4; i++) press_digit(c[15-4*i -: 4]);
      press_enter(sel);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge CLK);
      checks++; if (KEY !== 2'b01) begin errors++; $display("FAIL reset_key: got %b expected 01", KEY); end
      checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", LOCKED); end
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", ERR); end
      checks++; if (NDIG !== 3'd0) begin errors++; $display("FAIL reset_ndig: got %0d expected 0", NDIG); end
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_arm();
      do_reset();
      for (int i = 1; i <= 4; i++) press_digit(4'(i));
      checks++; if (NDIG !== 3'd4) begin errors++; $display("FAIL arm_ndig4: got %0d expected 4", NDIG); end
      press_enter(1'b1);
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL arm_err: got %b expected 0", ERR); end
      checks++; if (KEY !== 2'b01) begin errors++; $display("FAIL arm_key_check_cycle: got %b expected 01", KEY); end
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         checks++; if (KEY !== 2'b11) begin errors++; $display("FAIL arm_key_cycle%0d: got %b expected 11", i, KEY); end
      end
      @(negedge CLK);
      checks++; if (KEY !== 2'b01) begin errors++; $display("FAIL arm_key_end: got %b expected 01", KEY); end
      checks++; if (NDIG !== 3'd0) begin errors++; $display("FAIL arm_ndig_end: got %0d expected 0", NDIG); end
   endtask

   task automatic test_wrong_code();
      do_reset();
      enter_code(16'h1235, 1'b1);
      checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL wrong_err: got %b expected 1", ERR); end
      @(negedge CLK);
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL wrong_err_pulse: got %b expected 0", ERR); end
      checks++; if (KEY !== 2'b01) begin errors++; $display("FAIL wrong_key: got %b expected 01", KEY); end
      checks++; if (NDIG !== 3'd0) begin errors++; $display("FAIL wrong_ndig: got %0d expected 0", NDIG); end
   endtask

   task automatic test_lockout();
      logic       key_bad;
      int         n;
      logic [3:0] seq_d [5];
      seq_d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         enter_code(16'h9999, 1'b1);
         checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL lock_err%0d: got %b expected 1", k, ERR); end
         @(negedge CLK);
      end
      checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b expected 1", LOCKED); end
      key_bad = 1'b0;
      n = 0;
      while (LOCKED === 1'b1 && n < 40) begin
         if (KEY !== 2'b01) key_bad = 1'b1;
         DIGIT_STB = (n < 4); ENTER_STB = (n == 4); CMD_SEL = 1'b1;
         DIGIT = seq_d[n < 5 ? n : 4];
         @(negedge CLK);
         n++;
      end
      DIGIT_STB = 1'b0; ENTER_STB = 1'b0; CMD_SEL = 1'b0;
      checks++; if (key_bad !== 1'b0) begin errors++; $display("FAIL lock_key_moved: got KEY change during lockout, expected 01 throughout"); end
      checks++; if (n < 17 || n > 20) begin errors++; $display("FAIL lock_duration: got %0d cycles expected 17..20", n); end
      checks++; if (NDIG !== 3'd0) begin errors++; $display("FAIL lock_ndig: got %0d expected 0", NDIG); end
      enter_code(16'h1234, 1'b1);
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL lock_after_err: got %b expected 0", ERR); end
      @(negedge CLK);
      checks++; if (KEY !== 2'b11) begin errors++; $display("FAIL lock_after_key: got %b expected 11", KEY); end
      repeat (4) @(negedge CLK);
   endtask

   task automatic test_timeout();
      logic saw_err;
      do_reset();
      press_digit(4'h1);
      press_digit(4'h2);
      saw_err = 1'b0;
      for (int i = 0; i < 13; i++) begin
         if (ERR !== 1'b0) saw_err = 1'b1;
         if (i == 4) begin
            checks++; if (NDIG !== 3'd2) begin errors++; $display("FAIL tmo_ndig_early: got %0d expected 2", NDIG); end
         end
         @(negedge CLK);
      end
      checks++; if (NDIG !== 3'd0) begin errors++; $display("FAIL tmo_ndig: got %0d expected 0", NDIG); end
      checks++; if (saw_err !== 1'b0) begin errors++; $display("FAIL tmo_err: got ERR pulse expected none"); end
      enter_code(16'h1234, 1'b0);
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL tmo_disarm_err: got %b expected 0", ERR); end
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         checks++; if (KEY !== 2'b00) begin errors++; $display("FAIL tmo_disarm_key%0d: got %b expected 00", i, KEY); end
      end
      @(negedge CLK);
      checks++; if (KEY !== 2'b01) begin errors++; $display("FAIL tmo_disarm_end: got %b expected 01", KEY); end
   endtask

   task automatic test_extra_digits();
      do_reset();
      for (int i = 1; i <= 4; i++) press_digit(4'(i));
      press_digit(4'h9);
      checks++; if (NDIG !== 3'd4) begin errors++; $display("FAIL fifth_ndig: got %0d expected 4", NDIG); end
      press_enter(1'b1);
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL fifth_err: got %b expected 0", ERR); end
      @(negedge CLK);
      checks++; if (KEY !== 2'b11) begin errors++; $display("FAIL fifth_key: got %b expected 11", KEY); end
      repeat (4) @(negedge CLK);
      for (int i = 1; i <= 4; i++) press_digit(4'(i));
      DIGIT = 4'h7; DIGIT_STB = 1'b1; ENTER_STB = 1'b1; CMD_SEL = 1'b0;
      @(negedge CLK);
      DIGIT_STB = 1'b0; ENTER_STB = 1'b0;
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL same_cycle_err: got %b expected 0", ERR); end
      @(negedge CLK);
      checks++; if (KEY !== 2'b00) begin errors++; $display("FAIL same_cycle_key: got %b expected 00", KEY); end
      repeat (4) @(negedge CLK);
      for (int i = 1; i <= 3; i++) press_digit(4'(i));
      DIGIT = 4'h4; DIGIT_STB = 1'b1; ENTER_STB = 1'b1; CMD_SEL = 1'b1;
      @(negedge CLK);
      DIGIT_STB = 1'b0; ENTER_STB = 1'b0; CMD_SEL = 1'b0;
      checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL enter_wins_err: got %b expected 1", ERR); end
      @(negedge CLK);
      checks++; if (KEY !== 2'b01) begin errors++; $display("FAIL enter_wins_key: got %b expected 01", KEY); end
   endtask

   task automatic test_reset_mid_issue();
      do_reset();
      enter_code(16'h1234, 1'b1);
      @(negedge CLK);
      @(negedge CLK);
      checks++; if (KEY !== 2'b11) begin errors++; $display("FAIL rst_issue_pre: got %b expected 11", KEY); end
      RST = 1'b1;
      @(negedge CLK);
      checks++; if (KEY !== 2'b01) begin errors++; $display("FAIL rst_issue_key: got %b expected 01", KEY); end
      checks++; if (NDIG !== 3'd0) begin errors++; $display("FAIL rst_issue_ndig: got %0d expected 0", NDIG); end
      checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL rst_issue_locked: got %b expected 0", LOCKED); end
      RST = 1'b0;
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
         enter_code(16'hABCD, 1'b1);
         @(negedge CLK);
      end
      do_reset();
      enter_code(16'h4321, 1'b1);
      checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL rst_fail_err: got %b expected 1", ERR); end
      @(negedge CLK);
      checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL rst_fail_locked: got %b expected 0", LOCKED); end
      repeat (3) @(negedge CLK);
      checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL rst_fail_locked_late: got %b expected 0", LOCKED); end
   endtask

   initial begin
      test_reset();
      test_arm();
      test_wrong_code();
      test_lockout();
      test_timeout();
      test_extra_digits();
      test_reset_mid_issue();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
